lock_manager_multi: RTL and testbench

// - Successor to the single-lock arbiter. Serves NUM_LOCKS independent mutexes to up to MAX_ACCS accelerators.
// - Records the owner of every lock. An unlock is honoured only when it comes from the owning accelerator.
// - Sits on the OmpSs Manager command path: accelerator lock/unlock commands arrive on inStream; ACKs return on outStream, routed by TDEST.

---
 rtl/lock_manager_multi.sv | 177 +++++++++++++++++
 tb/tb_lock_manager_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_manager_multi.sv
// Multi-lock mutex manager on the OmpSs Manager command path: NUM_LOCKS locks with owner tracking.
// Command word: CMD_TYPE = TDATA[7:0], LOCK_ID = TDATA[15:8]. Define LOCK_UNLOCK_ACK_EN to acknowledge unlocks.
module lock_manager_multi #(
  parameter int MAX_ACCS  = 16,
  parameter int NUM_LOCKS = 8,
  localparam int ACC_BITS = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1,
  localparam int IDX_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          inStream_TDATA,
  input  logic                 inStream_TVALID,
  input  logic [ACC_BITS-1:0]  inStream_TID,
  output logic                 inStream_TREADY,
  output logic [63:0]          outStream_TDATA,
  output logic                 outStream_TVALID,
  input  logic                 outStream_TREADY,
  output logic [ACC_BITS-1:0]  outStream_TDEST,
  output logic [NUM_LOCKS-1:0] locked_o
);

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] NUM_LOCKS_ID    = 8'(NUM_LOCKS);

  typedef enum logic [1:0] {
    READ_HEADER = 2'd0,
    PROCESS     = 2'd1,
    SEND_ACK    = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [ACC_BITS-1:0]  tid_r;
  logic [7:0]           cmd_r;
  logic [7:0]           lock_id_r;
  logic [NUM_LOCKS-1:0] locked_r;
  logic [ACC_BITS-1:0]  owner_r [NUM_LOCKS];
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [7:0]           out_code_r;
  logic [ACC_BITS-1:0]  out_dest_r;

  logic [IDX_BITS-1:0]  idx_s;
  logic                 id_valid_s;
  logic                 held_s;
  logic                 is_owner_s;
  logic                 grant_s;
  logic                 release_s;
  logic [7:0]           ack_code_s;
  logic                 unused_s;

  assign unused_s = ^{inStream_TDATA[63:16]};

  // Lock-table lookup, command decode and next-state selection
  always_comb begin
    idx_s      = lock_id_r[IDX_BITS-1:0];
    id_valid_s = (lock_id_r < NUM_LOCKS_ID);
    held_s     = 1'b0;
    is_owner_s = 1'b0;
    if (id_valid_s) begin
      held_s     = locked_r[idx_s];
      is_owner_s = (owner_r[idx_s] == tid_r);
    end else begin
      held_s     = 1'b0;
      is_owner_s = 1'b0;
    end
    grant_s    = 1'b0;
    release_s  = 1'b0;
    ack_code_s = ACK_REJECT_CODE;
    state_s    = state_r;
    case (state_r)
      READ_HEADER: begin
        if (inStream_TVALID) begin
          state_s = PROCESS;
        end else begin
          state_s = READ_HEADER;
        end
      end
      PROCESS: begin
        if (cmd_r == CMD_LOCK_CODE) begin
          state_s = SEND_ACK;
          // Locks are non-reentrant: a held lock rejects even its owner.
          if (id_valid_s && !held_s) begin
            grant_s    = 1'b1;
            ack_code_s = ACK_OK_CODE;
          end else begin
            ack_code_s = ACK_REJECT_CODE;
          end
        end else if (cmd_r == CMD_UNLOCK_CODE) begin
          if (id_valid_s && held_s && is_owner_s) begin
            release_s  = 1'b1;
            ack_code_s = ACK_OK_CODE;
          end else begin
            ack_code_s = ACK_REJECT_CODE;
          end
`ifdef LOCK_UNLOCK_ACK_EN
          state_s = SEND_ACK;
`else
          state_s = READ_HEADER;
`endif
        end else begin
          state_s = READ_HEADER;
        end
      end
      SEND_ACK: begin
        if (outStream_TREADY) begin
          state_s = READ_HEADER;
        end else begin
          state_s = SEND_ACK;
        end
      end
      default: begin
        state_s = READ_HEADER;
      end
    endcase
  end

  // State register, registered handshake flags and command latch
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= READ_HEADER;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      tid_r       <= {ACC_BITS{1'b0}};
      cmd_r       <= 8'h00;
      lock_id_r   <= 8'h00;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == READ_HEADER);
      out_valid_r <= (state_s == SEND_ACK);
      if ((state_r == READ_HEADER) && inStream_TVALID) begin
        tid_r     <= inStream_TID;
        cmd_r     <= inStream_TDATA[7:0];
        lock_id_r <= inStream_TDATA[15:8];
      end
    end
  end

  // Lock table: held flags and owners, reset releases every lock
  always_ff @(posedge clk) begin
    if (!rstn) begin
      locked_r <= {NUM_LOCKS{1'b0}};
      for (int i = 0; i < NUM_LOCKS; i++) begin
        owner_r[i] <= {ACC_BITS{1'b0}};
      end
    end else begin
      if (grant_s) begin
        locked_r[idx_s] <= 1'b1;
        owner_r[idx_s]  <= tid_r;
      end
      if (release_s) begin
        locked_r[idx_s] <= 1'b0;
      end
    end
  end

  // ACK payload, loaded once on entry to SEND_ACK and held through back-pressure
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_code_r <= 8'h00;
      out_dest_r <= {ACC_BITS{1'b0}};
    end else if ((state_r == PROCESS) && (state_s == SEND_ACK)) begin
      out_code_r <= ack_code_s;
      out_dest_r <= tid_r;
    end
  end

  assign inStream_TREADY  = in_ready_r;
  assign outStream_TVALID = out_valid_r;
  assign outStream_TDATA  = {56'h0, out_code_r};
  assign outStream_TDEST  = out_dest_r;
  assign locked_o         = locked_r;

endmodule

// File: tb/tb_lock_manager_multi.sv
// Scoreboard bench for lock_manager_multi: directed scenarios plus randomized traffic vs. a lock-table model.
module tb_lock_manager_multi;

  localparam int MAX_ACCS  = 16;
  localparam int NUM_LOCKS = 8;
  localparam int ACC_BITS  = 4;
  localparam logic [7:0] LOCK   = 8'h04;
  localparam logic [7:0] UNLOCK = 8'h05;
  localparam logic [7:0] OTHER  = 8'h07;
  localparam logic [7:0] OK     = 8'h01;
  localparam logic [7:0] REJ    = 8'h00;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [63:0]          in_data = 64'h0;
  logic                 in_valid = 1'b0;
  logic [ACC_BITS-1:0]  in_tid = 4'h0;
  logic                 in_ready;
  logic [63:0]          out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_BITS-1:0]  out_dest;
  logic [NUM_LOCKS-1:0] locked_o;

  lock_manager_multi #(.MAX_ACCS(MAX_ACCS), .NUM_LOCKS(NUM_LOCKS)) dut (
    .clk(clk), .rstn(rstn),
    .inStream_TDATA(in_data), .inStream_TVALID(in_valid), .inStream_TID(in_tid),
    .inStream_TREADY(in_ready),
    .outStream_TDATA(out_data), .outStream_TVALID(out_valid), .outStream_TREADY(out_ready),
    .outStream_TDEST(out_dest), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_accept_cyc = 0;
  bit rand_mode = 1'b0;
  bit ready_force = 1'b1;
  logic prev_valid = 1'b0;
  logic [67:0] exp_q[$];

  // Reference model: which locks are held and by whom
  logic [NUM_LOCKS-1:0] m_locked = '0;
  int m_owner[NUM_LOCKS];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready <= rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endfunction

  function automatic void model_reset();
    m_locked = '0;
    for (int i = 0; i < NUM_LOCKS; i++) m_owner[i] = 0;
    exp_q.delete();
  endfunction

  // Apply one command to the model; returns 1 when an ACK is expected
  function automatic bit model_apply(logic [7:0] cmd, logic [7:0] id, logic [3:0] tid);
    logic [7:0] code;
    bit ack;
    bit valid_id;
    valid_id = (int'(id) < NUM_LOCKS);
    ack = 1'b0;
    code = REJ;
    if (cmd == LOCK) begin
      ack = 1'b1;
      if (valid_id && !m_locked[id]) begin
        m_locked[id] = 1'b1;
        m_owner[id] = int'(tid);
        code = OK;
      end
    end else if (cmd == UNLOCK) begin
      if (valid_id && m_locked[id] && m_owner[id] == int'(tid)) begin
        m_locked[id] = 1'b0;
        code = OK;
      end
`ifdef LOCK_UNLOCK_ACK_EN
      ack = 1'b1;
`endif
    end
    if (ack) exp_q.push_back({56'h0, code, tid});
    return ack;
  endfunction

  // Monitor: latency of each new ACK and scoreboard compare on every beat
  always @(negedge clk) begin
    if (rstn && out_valid === 1'b1 && prev_valid !== 1'b1)
      chk("ack_latency", 64'(cyc), 64'(last_accept_cyc + 1));
    prev_valid <= out_valid;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_ack");
      end else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        chk("ack_data", out_data, e[67:4]);
        chk("ack_dest", 64'(out_dest), 64'(e[3:0]));
      end
    end
  end

  task automatic send(input logic [7:0] cmd, input logic [7:0] id, input logic [3:0] tid,
                      input bit wait_done);
    int n;
    bit ack;
    logic [63:0] w;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail("accept_timeout");
      return;
    end
    w = {$urandom(), $urandom()};
    w[7:0] = cmd;
    w[15:8] = id;
    in_data = w;
    in_tid = tid;
    in_valid = 1'b1;
    ack = model_apply(cmd, id, tid);
    @(posedge clk);
    #1;
    last_accept_cyc = cyc;
    in_valid = 1'b0;
    in_tid = 4'($urandom());
    in_data = {$urandom(), $urandom()};
    @(negedge clk);
    chk("busy_ready", 64'(in_ready), 64'h0);
    if (!wait_done) return;
    if (!ack) begin
      @(negedge clk);
      chk("silent_ready", 64'(in_ready), 64'h1);
    end
    n = 0;
    while (!(in_ready === 1'b1 && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("done_timeout");
    chk("locked_o", 64'(locked_o), 64'(m_locked));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("valid_timeout");
  endtask

  initial begin
    logic [7:0] c;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_dest", 64'(out_dest), 64'h0);
    chk("rst_locked", 64'(locked_o), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    rstn = 1'b1;

    // Directed ownership scenarios
    send(LOCK,   8'd2, 4'd3, 1'b1);
    send(LOCK,   8'd2, 4'd5, 1'b1);
    send(LOCK,   8'd2, 4'd3, 1'b1);
    send(UNLOCK, 8'd2, 4'd5, 1'b1);
    send(UNLOCK, 8'd2, 4'd3, 1'b1);
    send(LOCK,   8'd2, 4'd5, 1'b1);
    send(LOCK,   8'd9, 4'd1, 1'b1);
    send(OTHER,  8'd2, 4'd1, 1'b1);
    send(UNLOCK, 8'd9, 4'd1, 1'b1);
    send(LOCK,   8'd7, 4'd15, 1'b1);
    send(UNLOCK, 8'd2, 4'd5, 1'b1);

    // Back-pressure: ACK must hold steady and inStream must stall
    ready_force = 1'b0;
    send(LOCK, 8'd4, 4'd6, 1'b0);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'h1);
      chk("stall_data", out_data, {56'h0, OK});
      chk("stall_dest", 64'(out_dest), 64'd6);
      chk("stall_in_ready", 64'(in_ready), 64'h0);
    end
    ready_force = 1'b1;
    send(LOCK, 8'd5, 4'd6, 1'b1);

    // Reset while an ACK is pending with locks 0 and 1 held
    send(LOCK, 8'd0, 4'd1, 1'b1);
    send(LOCK, 8'd1, 4'd2, 1'b1);
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    send(LOCK, 8'd3, 4'd4, 1'b0);
    wait_valid();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_locked", 64'(locked_o), 64'h0);
    chk("rst_mid_ready", 64'(in_ready), 64'h1);
    rstn = 1'b1;
    model_reset();
    ready_force = 1'b1;
    repeat (10) @(negedge clk);
    send(LOCK, 8'd0, 4'd7, 1'b1);

    // Randomized traffic with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) c = LOCK;
      else if (r < 9) c = UNLOCK;
      else c = 8'($urandom_range(8, 255));
      send(c, 8'($urandom_range(0, 9)), 4'($urandom_range(0, 3)), 1'b1);
    end
    rand_mode = 1'b0;
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) fail("ack_left_over");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
